// File: rtl/rng_xorshift_multi.sv
// rtl/rng_xorshift_multi.sv - multi-channel xorshift32 uniform source with warm-up and valid/ready output
module rng_xorshift_multi #(
  parameter int          NUM_CH   = 4,
  parameter int          WARMUP   = 16,
  parameter logic [31:0] SEED_MIX = 32'h9E3779B9
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_seed_load,
  input  logic [31:0]            i_seed,
  input  logic                   i_out_ready,
  output logic                   o_out_valid,
  output logic [NUM_CH*32-1:0]   o_out_data,
  output logic                   o_busy,
  output logic [31:0]            o_draws
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  // Counter value loaded with a seed: the warm-up ends on the step taken at count 0.
  localparam logic [7:0] LP_WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_draws;
  logic        w_fire;
  logic        w_step;

  // One xorshift32 step (13, 17, 5); shifts drop bits so everything is mod 2^32.
  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // A draw is consumed only in RUN; a simultaneous seed load wins and discards it.
  assign w_fire = (r_state == S_RUN) && i_out_ready;
  assign w_step = !i_seed_load && ((r_state == S_WARMUP) || w_fire);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: seed load from any state restarts the sequence.
  always_comb begin
    w_next_state = r_state;
    if (i_seed_load) begin
      w_next_state = (WARMUP == 0) ? S_RUN : S_WARMUP;
    end else begin
      case (r_state)
        S_WARMUP: if (r_cnt == 8'd0) w_next_state = S_RUN;
        default:  w_next_state = r_state;
      endcase
    end
  end

  // Outputs decoded from the state alone.
  always_comb begin
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_WARMUP: o_busy      = 1'b1;
      S_RUN:    o_out_valid = 1'b1;
      default:  ;
    endcase
  end

  // Warm-up step counter, reloaded on every seed load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_seed_load) begin
      r_cnt <= LP_WARM_LAST;
    end else if ((r_state == S_WARMUP) && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  // Accepted-transfer counter; wraps naturally at 2^32.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_draws <= 32'd0;
    end else if (i_seed_load) begin
      r_draws <= 32'd0;
    end else if (w_fire) begin
      r_draws <= r_draws + 32'd1;
    end
  end

  assign o_draws = r_draws;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [31:0] LP_MIX = 32'(g * SEED_MIX);

    logic [31:0] r_x;
    logic [31:0] w_seed_raw;
    logic [31:0] w_seed_ch;

    // A zero state would lock xorshift at zero forever, so it is replaced by 1.
    assign w_seed_raw = i_seed ^ LP_MIX;
    assign w_seed_ch  = (w_seed_raw == 32'd0) ? 32'd1 : w_seed_raw;

    // Channel state: all channels load and step on the same conditions.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_x <= 32'd0;
      end else if (i_seed_load) begin
        r_x <= w_seed_ch;
      end else if (w_step) begin
        r_x <= xs_step(r_x);
      end
    end

    // Q8.24 uniform in [0,1): top 24 state bits as the fraction.
    assign o_out_data[32*g +: 32] = {8'h00, r_x[31:8]};
  end

endmodule

// File: tb/tb_rng_xorshift_multi.sv
// tb/tb_rng_xorshift_multi.sv - randomized model-checked bench for rng_xorshift_multi
module tb_rng_xorshift_multi;

  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              seed_load = 1'b0;
  logic [31:0]       seed = 32'd0;
  logic              out_ready = 1'b0;

  logic              v0, b0, v3, b3;
  logic [NCH*32-1:0] d0, d3;
  logic [31:0]       dr0, dr3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rng_xorshift_multi #(.NUM_CH(NCH), .WARMUP(0), .SEED_MIX(32'h9E3779B9)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_seed_load(seed_load), .i_seed(seed),
    .i_out_ready(out_ready), .o_out_valid(v0), .o_out_data(d0), .o_busy(b0), .o_draws(dr0)
  );

  rng_xorshift_multi #(.NUM_CH(NCH), .WARMUP(3), .SEED_MIX(32'h9E3779B9)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_seed_load(seed_load), .i_seed(seed),
    .i_out_ready(out_ready), .o_out_valid(v3), .o_out_data(d3), .o_busy(b3), .o_draws(dr3)
  );

  // Reference model: index 0 is the W=0 instance, index 1 the W=3 instance.
  int          wcfg [2] = '{0, 3};
  int unsigned mx [2][NCH];
  int          mst [2];      // 0 idle, 1 warming up, 2 running
  int          mleft [2];    // warm-up steps still to take
  int unsigned mdr [2];

  function automatic int unsigned xs(input int unsigned x);
    int unsigned t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic int unsigned mseed(input int unsigned s, input int i);
    int unsigned m;
    int unsigned t;
    m = i;
    t = s ^ (m * 32'h9E3779B9);
    if (t == 0) t = 1;
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mst[k] = 0; mleft[k] = 0; mdr[k] = 0;
        for (int c = 0; c < NCH; c++) mx[k][c] = 0;
      end else if (seed_load) begin
        for (int c = 0; c < NCH; c++) mx[k][c] = mseed(seed, c);
        mdr[k] = 0;
        if (wcfg[k] == 0) mst[k] = 2;
        else begin mst[k] = 1; mleft[k] = wcfg[k]; end
      end else if (mst[k] == 1) begin
        for (int c = 0; c < NCH; c++) mx[k][c] = xs(mx[k][c]);
        mleft[k] = mleft[k] - 1;
        if (mleft[k] == 0) mst[k] = 2;
      end else if (mst[k] == 2 && out_ready) begin
        for (int c = 0; c < NCH; c++) mx[k][c] = xs(mx[k][c]);
        mdr[k] = mdr[k] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("w0_valid", 32'(v0), 32'(mst[0] == 2));
    chk("w0_busy",  32'(b0), 32'(mst[0] == 1));
    chk("w0_draws", dr0, mdr[0]);
    chk("w3_valid", 32'(v3), 32'(mst[1] == 2));
    chk("w3_busy",  32'(b3), 32'(mst[1] == 1));
    chk("w3_draws", dr3, mdr[1]);
    for (int c = 0; c < NCH; c++) begin
      chk("w0_data", d0[32*c +: 32], mx[0][c] >> 8);
      chk("w3_data", d3[32*c +: 32], mx[1][c] >> 8);
    end
  endtask

  always @(negedge clk) compare_all();

  task automatic step(input logic sl, input logic [31:0] sd, input logic rdy);
    seed_load = sl;
    seed      = sd;
    out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    #1;
    seed_load = 1'b0;
    out_ready = 1'b0;
  endtask

  logic [NCH*32-1:0] prev;
  int busy_n;

  initial begin
    @(negedge clk); #1;
    step(0, 0, 0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_draws", dr0, 32'd0);
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("idle_after_rst", 32'(v0), 32'd0);

    // seed=1, W=0
    step(1, 32'd1, 0);
    chk("s1_valid", 32'(v0), 32'd1);
    chk("s1_ch0", d0[31:0], 32'h00000000);
    chk("s1_draws", dr0, 32'd0);
    step(0, 0, 1);
    chk("s1_ch0_step", d0[31:0], 32'h00000420);
    chk("s1_draws1", dr0, 32'd1);
    chk("model_pin_x0", mx[0][0], 32'h00042021);

    // seed=0: zero guard on ch0
    step(1, 32'd0, 0);
    chk("s0_ch0", d0[31:0], 32'h00000000);
    chk("s0_ch1", d0[63:32], 32'h009E3779);
    chk("s0_ch2", d0[95:64], 32'h003C6EF3);
    chk("model_pin_x2", mx[0][2], 32'h3C6EF372);
    chk("model_pin_guard", mx[0][0], 32'h00000001);

    // seed=1, W=3 warm-up length
    step(1, 32'd1, 0);
    busy_n = 0;
    for (int t = 0; t < 20 && !v3; t++) begin
      if (b3) busy_n++;
      step(0, 0, 0);
    end
    chk("w3_busy_cycles", busy_n, 32'd3);
    chk("w3_valid_up", 32'(v3), 32'd1);
    chk("model_pin_w3", mx[1][0], xs(xs(xs(32'd1))));

    // back-pressure pattern 1,0,0,1
    step(1, 32'd5, 0);
    prev = d0;
    step(0, 0, 1);
    chk("bp_changed1", 32'(d0 != prev), 32'd1);
    prev = d0;
    step(0, 0, 0);
    chk("bp_hold1", 32'(d0 == prev), 32'd1);
    step(0, 0, 0);
    chk("bp_hold2", 32'(d0 == prev), 32'd1);
    step(0, 0, 1);
    chk("bp_changed2", 32'(d0 != prev), 32'd1);
    chk("bp_draws", dr0, 32'd2);

    // seed_load wins over fire
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 32'd1, 1);
    chk("sl_fire_draws", dr0, 32'd0);
    chk("sl_fire_ch0", d0[31:0], 32'h00000000);
    chk("sl_fire_ch1", d0[63:32], 32'h009E3779);

    // reset mid-warm-up, checked without a clock edge
    step(1, 32'd7, 0);
    step(0, 0, 0);
    chk("mid_warm_busy", 32'(b3), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(v3), 32'd0);
    chk("arst_busy", 32'(b3), 32'd0);
    chk("arst_data", d3[31:0], 32'd0);
    chk("arst_data0", d0[31:0], 32'd0);
    compare_all();
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) step(0, 0, 1);
    chk("idle_hold_v0", 32'(v0), 32'd0);
    chk("idle_hold_v3", 32'(v3), 32'd0);

    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      logic [31:0] sd;
      sd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom;
      step(($urandom_range(0, 19) == 0), sd, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rng_xorshift_multi.md
# rng_xorshift_multi

Parametrised multi-channel uniform random-number source for the Heston path engine. It generalises the single 32-bit shift-register generator to NUM_CH independent xorshift32 channels seeded from one base seed, with a zero-seed guard, a warm-up discard phase, runtime reseeding and a valid/ready output handshake. Each channel emits a Q8.24 uniform in [0,1). The block feeds the variance and price path units, which consume one draw per channel per accepted transfer.

## Interface
- NUM_CH, 4: number of independent channels (1..16).
- WARMUP, 16: steps discarded after each seed load (0..255).
- SEED_MIX, 32'h9E3779B9: per-channel seed offset constant.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- seed_load  in  1  single-cycle request to (re)seed all channels.
- seed  in  32  base seed, sampled when seed_load=1.
- out_ready  in  1  consumer accepts the current draw.
- out_valid  out  1  out_data holds a valid draw vector.
- out_data  out  NUM_CH*32  channel i in bits [32i+31:32i], Q8.24.
- busy  out  1  high in WARMUP.
- draws  out  32  count of accepted transfers since the last seed load.

## Operation
- Per-channel state x_i, 32 bits. Step function, all operations mod 2^32: x ^= x<<13; x ^= x>>17; x ^= x<<5.
- Seed derivation: s_i = seed ^ (i*SEED_MIX) truncated to 32 bits. If s_i == 0, s_i is replaced by 32'h00000001.
- Output format: out_data_i = {8'h00, x_i[31:8]}. It is driven directly from the state registers with no extra logic.
- FSM states: IDLE, WARMUP, RUN.
  - IDLE: entered on reset. out_valid=0, busy=0. Waits for seed_load.
  - seed_load=1 in any state: x_i <= s_i and draws <= 0.
    - If WARMUP==0, go to RUN.
    - Otherwise go to WARMUP with the step counter set to WARMUP-1.
  - WARMUP: every cycle, all channels step and the counter decrements. When the counter is 0, the final step is taken and the FSM goes to RUN.
  - RUN: out_valid=1. A fire (out_valid & out_ready) steps all channels and increments draws, which wraps at 2^32. With no fire, the state holds.
- seed_load has priority over fire and over warm-up stepping. A fire in the same cycle as seed_load is discarded and draws is not incremented.
- All channels always step together; channels never advance independently.
- seed_load during WARMUP restarts the warm-up from the new seed.

## Timing
- Reset values: FSM=IDLE, every x_i=0, out_data=0, out_valid=0, busy=0, draws=0. These apply immediately on the reset assertion, independent of clk.
- Let seed_load be sampled at edge E0:
  - With WARMUP=W>0: busy=1 after E0. Steps occur at edges E1..EW. After EW, busy=0 and out_valid=1. Latency is W+1 edges.
  - With W=0: out_valid=1 after E0, and out_data equals the formatted seeds.
- out_valid drops the cycle after a seed_load sampled in RUN. It stays low for W cycles, or for 0 cycles if W=0.
- In RUN, throughput is one draw per cycle while out_ready=1.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation aborts everything: the block returns to IDLE and must be reseeded. Deassertion of reset alone never produces out_valid.

## Test plan
- Reset, then seed_load with seed=1, NUM_CH=4, W=0:
  - Next cycle: out_valid=1, ch0=32'h00000000, draws=0.
  - Hold out_ready=1 for one cycle: ch0 becomes 32'h00000420 (state 32'h00042021) and draws=1.
- seed=0, W=0:
  - ch0 state is 1, because the zero guard applies.
  - ch1 state is 32'h9E3779B9, so ch1 out_data=32'h009E3779.
  - ch2 state is 32'h3C6EF372.
- seed=1, W=3:
  - busy is high for exactly 3 cycles after the load edge.
  - out_valid rises with ch0 equal to the formatted 3-step xorshift of 1, matching the reference model.
- Back-pressure: in RUN, toggle out_ready in the pattern 1,0,0,1.
  - out_data changes only after cycles with out_ready=1.
  - draws=2.
- seed_load and out_ready both high in RUN, W=0:
  - The state is reloaded from the new seed with no extra step.
  - draws=0.
- Assert reset mid-WARMUP, then release it:
  - out_valid=0, busy=0 and out_data=0 with no clock edge required.
  - The block stays in IDLE until the next seed_load.
